load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage between the execute stage and `data_memory`. It accepts one load or store request at a time over a valid/ready handshake, drives the word-addressed data memory, and does read-modify-write for byte and halfword stores. Loads have their bytes extracted and sign- or zero-extended, and the result goes to the register file write port as a one-cycle writeback pulse.

## Interface
- `DATA_W`, default 32: data/address width; equals `MAX_LENGTH`.
- `REG_W`, default 5: register index width; equals `REG_LENGTH`.

Ports:
- `clk`  in  1  clock, posedge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted on a posedge where `req_valid & req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  DATA_W  byte address.
- `req_wdata`  in  DATA_W  store data, right-justified.
- `req_dest`  in  REG_W  load destination register.
- `mem_address`  out  DATA_W  word-aligned address (bits 1:0 = 0).
- `mem_read_enabled`  out  1  memory read strobe.
- `mem_write_enabled`  out  1  memory write strobe.
- `mem_wdata`  out  DATA_W  full word to write.
- `mem_rdata`  in  DATA_W  combinational memory read data.
- `wb_valid`  out  1  one-cycle writeback pulse.
- `wb_dest`  out  REG_W  writeback register.
- `wb_data`  out  DATA_W  writeback value.
- `err`  out  1  one-cycle misalignment pulse.

## Operation
- States: IDLE, READ, WRITE, RESP, ERR.
- Acceptance captures every `req_*` field into internal registers. Inputs are ignored outside IDLE.
- Memory byte order is big-endian. Byte offset k (`addr[1:0]`) is word bits [31-8k -: 8]. Half offset 0 is [31:16]; half offset 2 is [15:0].
- Transitions from IDLE:
  - Load → READ.
  - Word store → WRITE.
  - Byte or half store → READ.
  - Misaligned access (with macro only) → ERR.
- READ: drives `mem_address` and `mem_read_enabled`=1, then samples `mem_rdata` at the posedge.
  - Load: extract lane, extend, register into `wb_data`/`wb_dest` → RESP.
  - Byte/half store: merge the store lane into the sampled word → WRITE.
- WRITE: `mem_write_enabled`=1 and `mem_wdata` = full word (word store) or merged word (byte/half store) → IDLE.
- RESP: `wb_valid`=1 when `wb_dest` ≠ 0; `wb_valid` stays 0 when `wb_dest` = 0 → IDLE.
- ERR: `err`=1, no memory strobe, no writeback → IDLE.
- `req_ready` = (state == IDLE) and reset deasserted.
- Memory strobes are decoded combinationally from state, so they drop in the same instant reset asserts.
- Reset values: state IDLE; `req_ready`, `mem_*` strobes, `mem_address`, `mem_wdata`, `wb_valid`, `wb_dest`, `wb_data`, `err` all 0.
- Reset mid-operation abandons the request; a store in READ never writes memory.

## Timing
- Acceptance edge is E0.
- Load: READ in E0–E1; `wb_valid` high E1–E2. Throughput is one load per 3 cycles.
- Word store: write occurs at E1. Throughput 2 cycles.
- Byte/half store: read E0–E1, write at E2. Throughput 3 cycles.
- Misaligned (macro on): `err` high E0–E1. Throughput 2 cycles.
- The register file writes on negedge, so `wb_*` is stable for the full RESP cycle.
- No combinational path from `req_*` to any output.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half access with `addr[0]`=1 or a word access with `addr[1:0]`≠0 goes to ERR. It makes no memory access and no writeback.
- Not defined: no misalignment check. Half ignores `addr[0]`, word ignores `addr[1:0]`. `err` is tied 0 and the ERR state is not built.

## Structure
- Add to the shared `defines.v`: `SIZE_BYTE`/`SIZE_HALF`/`SIZE_WORD` encodings and LSU state encodings. Reuse `MAX_LENGTH` and `REG_LENGTH`.
- One sub-module, `mem_lane_align`, is purely combinational:
  - load extract and extend (word, offset, size, signed → value);
  - store merge (old word, data, offset, size → new word).

## Test plan
- Word store 0x12345678 @0x40, then word load @0x40 to dest 5 → `wb_data`=0x12345678, `wb_dest`=5, `wb_valid` one cycle, E1–E2.
- Byte store 0xAB @0x41 over 0x12345678 → memory word 0x12AB5678; exactly one read strobe, then one write strobe.
- On 0x12AB5678:
  - signed byte load @0x41 → 0xFFFFFFAB;
  - unsigned byte load @0x41 → 0x000000AB;
  - signed half load @0x42 → 0x00005678;
  - signed half load @0x40 → 0x000012AB.
- Load to dest 0 → no `wb_valid`. A second request held on `req_valid` during busy is accepted only at the next IDLE edge and is not duplicated.
- Word load @0x42:
  - macro on → `err` one cycle, no strobes, no writeback;
  - macro off → reads word @0x40.
- Reset low during WRITE of a byte store → `mem_write_enabled` drops immediately, all outputs 0, memory unchanged; `req_ready`=1 on the first cycle after release.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared widths, access-size encodings and LSU state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int MAX_LENGTH = 32;
    localparam int REG_LENGTH = 5;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] LSU_IDLE  = 3'd0;
    localparam logic [2:0] LSU_READ  = 3'd1;
    localparam logic [2:0] LSU_WRITE = 3'd2;
    localparam logic [2:0] LSU_RESP  = 3'd3;
    localparam logic [2:0] LSU_ERR   = 3'd4;

    // Size code 11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Big-endian lane extract/extend for loads and lane merge for
//               byte/half stores. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = MAX_LENGTH
) (
    input  logic [DATA_W-1:0] i_word,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_offset,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_load,
    output logic [DATA_W-1:0] o_merged
);

    logic [4:0]        w_shift;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_lane;
    logic              w_sign;

    // Offset 0 is the most significant lane, so the shift is (3-k) lanes.
    always_comb begin
        w_shift = 5'd0;
        w_mask  = '1;
        w_sign  = 1'b0;
        w_lane  = i_word;
        if (i_size == SIZE_BYTE) begin
            w_shift = {~i_offset, 3'b000};
            w_mask  = {{(DATA_W-8){1'b0}}, 8'hFF};
            w_lane  = (i_word >> w_shift) & w_mask;
            w_sign  = w_lane[7];
        end else if (i_size == SIZE_HALF) begin
            w_shift = {~i_offset[1], 4'b0000};
            w_mask  = {{(DATA_W-16){1'b0}}, 16'hFFFF};
            w_lane  = (i_word >> w_shift) & w_mask;
            w_sign  = w_lane[15];
        end
    end

    assign o_load   = (i_signed && w_sign) ? (w_lane | ~w_mask) : w_lane;
    assign o_merged = (i_word & ~(w_mask << w_shift)) | ((i_wdata & w_mask) << w_shift);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage: one load/store at a time, RMW for sub-word
//               stores, writeback pulse for loads. Optional macro
//               LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = MAX_LENGTH,
    parameter int REG_W  = REG_LENGTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_W-1:0]  req_dest,
    output logic [DATA_W-1:0] mem_address,
    output logic              mem_read_enabled,
    output logic              mem_write_enabled,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    logic [2:0]        r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [DATA_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [REG_W-1:0]  r_dest;
    logic [REG_W-1:0]  r_wb_dest;
    logic [DATA_W-1:0] r_wb_data;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((req_size == SIZE_HALF) && req_addr[0]) ||
                        (is_word(req_size) && (req_addr[1:0] != 2'b00));
`endif

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_word   (mem_rdata),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= LSU_IDLE;
            r_write   <= 1'b0;
            r_size    <= SIZE_BYTE;
            r_signed  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_dest    <= '0;
            r_wb_dest <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_dest   <= req_dest;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misalign)
                            r_state <= LSU_ERR;
                        else
`endif
                        if (req_write && is_word(req_size))
                            r_state <= LSU_WRITE;
                        else
                            r_state <= LSU_READ;
                    end
                end
                LSU_READ: begin
                    // Sub-word stores reuse the read to build the full word.
                    if (r_write) begin
                        r_wdata <= w_merged;
                        r_state <= LSU_WRITE;
                    end else begin
                        r_wb_data <= w_load;
                        r_wb_dest <= r_dest;
                        r_state   <= LSU_RESP;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign req_ready         = (r_state == LSU_IDLE) && reset;
    assign mem_read_enabled  = (r_state == LSU_READ);
    assign mem_write_enabled = (r_state == LSU_WRITE);
    assign mem_address       = {r_addr[DATA_W-1:2], 2'b00};
    assign mem_wdata         = r_wdata;
    assign wb_valid          = (r_state == LSU_RESP) && (r_wb_dest != '0);
    assign wb_dest           = r_wb_dest;
    assign wb_data           = r_wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    assign err               = (r_state == LSU_ERR);
`else
    assign err               = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench; byte-array big-endian reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_dest = 5'h0;
    logic [31:0] mem_address;
    logic        mem_read_enabled;
    logic        mem_write_enabled;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        err;

    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [7:0]  refm [0:255];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_write_enabled) mem[mem_address[7:2]] <= mem_wdata;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dest(req_dest),
        .mem_address(mem_address), .mem_read_enabled(mem_read_enabled),
        .mem_write_enabled(mem_write_enabled), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .wb_data(wb_data), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {refm[b], refm[b + 8'd1], refm[b + 8'd2], refm[b + 8'd3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [7:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [7:0]  e;
        if (sz == 2'b00) begin
            b = refm[a];
            return sg ? {{24{b[7]}}, b} : {24'h0, b};
        end else if (sz == 2'b01) begin
            e = {a[7:1], 1'b0};
            h = {refm[e], refm[e + 8'd1]};
            return sg ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
        logic [7:0] e;
        if (sz == 2'b00) begin
            refm[a] = wd[7:0];
        end else if (sz == 2'b01) begin
            e = {a[7:1], 1'b0};
            refm[e] = wd[15:8];
            refm[e + 8'd1] = wd[7:0];
        end else begin
            e = {a[7:2], 2'b00};
            refm[e] = wd[31:24];
            refm[e + 8'd1] = wd[23:16];
            refm[e + 8'd2] = wd[15:8];
            refm[e + 8'd3] = wd[7:0];
        end
    endtask

    function automatic bit ref_misal(input logic [1:0] sz, input logic [7:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return (sz == 2'b11) && (a == 8'hFF) && 1'b0;
`endif
    endfunction

    // One request from acceptance until the unit is idle again; every
    // per-cycle strobe and pulse is tallied and compared with the model.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [7:0] a, input logic [31:0] wd, input logic [4:0] d);
        int busy = -1, nrd = 0, nwr = 0, nwb = 0, nerr = 0, rdc = 0, wrc = 0, wbc = 0;
        logic [31:0] wbd = 32'h0;
        logic [4:0]  wbdst = 5'h0;
        bit done = 0;
        @(negedge clk);
        chk("ready_before", {31'h0, req_ready}, 32'h1);
        req_write = w; req_size = sz; req_signed = sg; req_addr = {24'h0, a};
        req_wdata = wd; req_dest = d; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w; req_size = ~sz; req_signed = ~sg;
        req_addr = $urandom; req_wdata = $urandom; req_dest = ~d;
        for (int c = 1; c <= 8 && !done; c++) begin
            @(negedge clk);
            if (req_ready) begin
                busy = c - 1;
                done = 1;
            end else begin
                if (mem_read_enabled) begin nrd++; rdc = c; end
                if (mem_write_enabled) begin nwr++; wrc = c; end
                if (err) nerr++;
                if (wb_valid) begin nwb++; wbc = c; wbd = wb_data; wbdst = wb_dest; end
            end
        end
        if (!done) chk("timeout", 32'h0, 32'h1);
        if (ref_misal(sz, a)) begin
            chk("err_busy", busy, 1);
            chk("err_pulse", nerr, 1);
            chk("err_strobes", nrd + nwr + nwb, 0);
        end else if (!w) begin
            chk("ld_busy", busy, 2);
            chk("ld_read", {nrd[15:0], rdc[15:0]}, {16'd1, 16'd1});
            chk("ld_nowrite", nwr + nerr, 0);
            chk("ld_wbcount", nwb, (d != 5'd0) ? 1 : 0);
            if (d != 5'd0) begin
                chk("ld_wbcycle", wbc, 2);
                chk("ld_wbdest", {27'h0, wbdst}, {27'h0, d});
                chk("ld_wbdata", wbd, ref_load(sz, sg, a));
            end
        end else begin
            if (sz[1]) begin
                chk("sw_busy", busy, 1);
                chk("sw_read", nrd, 0);
                chk("sw_write", {nwr[15:0], wrc[15:0]}, {16'd1, 16'd1});
            end else begin
                chk("sb_busy", busy, 2);
                chk("sb_read", {nrd[15:0], rdc[15:0]}, {16'd1, 16'd1});
                chk("sb_write", {nwr[15:0], wrc[15:0]}, {16'd1, 16'd2});
            end
            chk("st_nowb", nwb + nerr, 0);
            ref_store(sz, a, wd);
            chk("st_memword", mem[a[7:2]], ref_word(a));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {27'h0, req_ready, mem_read_enabled, mem_write_enabled, wb_valid, err}, 32'h0);
        chk(tag, mem_address | mem_wdata | wb_data, 32'h0);
        chk(tag, {27'h0, wb_dest}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nrd, nwr, nwb, nrdy;
        logic [31:0] wbd, wdh;
        for (int i = 0; i < 256; i++) refm[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b1;
        #1;
        chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        run_req(1'b1, 2'b10, 1'b0, 8'h40, 32'h12345678, 5'd0);
        run_req(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, 5'd5);
        run_req(1'b1, 2'b00, 1'b0, 8'h41, 32'h000000AB, 5'd0);
        chk("byte_merge", mem[16], 32'h12AB5678);
        run_req(1'b0, 2'b00, 1'b1, 8'h41, 32'h0, 5'd1);
        run_req(1'b0, 2'b00, 1'b0, 8'h41, 32'h0, 5'd2);
        run_req(1'b0, 2'b01, 1'b1, 8'h42, 32'h0, 5'd3);
        run_req(1'b0, 2'b01, 1'b1, 8'h40, 32'h0, 5'd4);
        run_req(1'b0, 2'b10, 1'b0, 8'h40, 32'h0, 5'd0);
        run_req(1'b0, 2'b10, 1'b0, 8'h42, 32'h0, 5'd9);
        run_req(1'b0, 2'b01, 1'b0, 8'h43, 32'h0, 5'd10);

        // Store then a load held on req_valid through the busy period.
        nrd = 0; nwr = 0; nwb = 0; nrdy = 0; wbd = 32'h0;
        wdh = $urandom;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h80; req_wdata = wdh;
        req_dest = 5'd0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_write = 1'b0; req_signed = 1'b0; req_dest = 5'd7;
        for (int c = 0; c < 12 && nrdy < 2; c++) begin
            @(negedge clk);
            if (mem_read_enabled) nrd++;
            if (mem_write_enabled) nwr++;
            if (wb_valid) begin nwb++; wbd = wb_data; end
            if (req_ready) begin
                nrdy++;
                if (nrdy == 1) begin
                    @(posedge clk);
                    #1;
                    req_valid = 1'b0;
                end
            end
        end
        ref_store(2'b10, 8'h80, wdh);
        chk("held_ready_twice", nrdy, 2);
        chk("held_counts", {8'h0, nrd[7:0], nwr[7:0], nwb[7:0]}, 32'h00010101);
        chk("held_wbdata", wbd, ref_load(2'b10, 1'b0, 8'h80));

        // Reset asserted while a byte store is in WRITE.
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_addr = 32'h41; req_wdata = 32'hCD;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_read", {31'h0, mem_read_enabled}, 32'h1);
        @(negedge clk);
        chk("rst_mid_write", {31'h0, mem_write_enabled}, 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("rst_mid_outputs");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_mem", mem[16], ref_word(8'h40));

        for (int i = 0; i < 60; i++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    $urandom, 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
